vpu_lifecycle_tracker: RTL and testbench
========================================

// Module: vpu_lifecycle_tracker
// PURPOSE
// Synthesisable, parametrised successor to the simulation-only VPU Kanata profiler. Taps dispatch, issue-queue enq/deq
// and VAT-release strobes; keeps a per-VAT-tag lifecycle table (ID + stage timestamps); on release pushes one
// lifecycle record per instruction into a multi-write FIFO drained by a valid/ready trace port. Sits beside vector_unit.
// PARAMETERS
// NUM_VAT    32  VAT tag entries; VAT_W = $clog2(NUM_VAT)
// NUM_ISSQ    5  issue queues tapped (vl, vs, vp, vx_int, vx_fp order)
// NUM_REL     4  VAT release ports per cycle
// ID_W       32  instruction ID width
// TS_W       32  cycle timestamp width
// FIFO_DEPTH 16  record FIFO entries, power of 2, >= NUM_REL
// PORTS
// clock          in  1               clock
// reset          in  1               asynchronous, active-high reset
// enable         in  1               1: records pushed; 0: table tracks, no pushes
// dis_fire       in  1               dispatch handshake (dis_valid & dis_ready)
// dis_vat        in  VAT_W           tag allocated at dispatch
// enq_fire       in  NUM_ISSQ        per-queue enq handshake
// enq_vat        in  NUM_ISSQ*VAT_W  per-queue enq tag
// deq_fire       in  NUM_ISSQ        per-queue deq handshake
// deq_vat        in  NUM_ISSQ*VAT_W  per-queue deq tag
// rel_valid      in  NUM_REL         VAT release strobes
// rel_vat        in  NUM_REL*VAT_W   released tags
// rec_valid      out 1               record available
// rec_ready      in  1               consumer accepts
// rec            out $bits(lc_rec_t) {id, t_dis, t_enq, t_deq, t_rel, qidx, flags}
// inflight       out VAT_W+1         valid table entries
// drop_cnt       out 16              saturating count of records lost to FIFO full
// err_reuse      out 1               sticky: dispatch hit already-valid tag
// err_orphan     out 1               sticky: enq/deq/release on invalid tag
// BEHAVIOUR
// - Reset: all outputs 0, table valid bits 0, cycle counter 0, next_id 1, FIFO empty.
// - Cycle counter TS_W bits, +1 every cycle, wraps; timestamps modulo 2^TS_W.
// - Dispatch: entry[dis_vat] <= {valid=1, id=next_id, t_dis=now, t_enq/t_deq=0, qidx=0, flags=0};
//   next_id++ (wraps modulo 2^ID_W). Target already valid: overwrite, set err_reuse.
// - Enq q: valid entry -> t_enq=now, qidx=q, flags.ENQ=1; several queues same tag/cycle -> lowest q wins.
//   Deq identical -> t_deq, flags.DEQ=1. Enq+deq same tag same cycle: both stamped with now.
// - Release port r on valid entry: record {entry, t_rel=now} goes to FIFO; entry invalidated next edge.
//   Releases read pre-cycle table: same-cycle enq/deq on released tag are not in record.
// - Release + dispatch same tag same cycle: record = old contents; entry ends holding new dispatch.
// - Two release ports same tag same cycle: one record (lowest port), second ignored.
// - Invalid-tag enq/deq/release: ignored, err_orphan set. Sticky errors clear only on reset.
// - FIFO: push count = valid releases (enable=1); free = DEPTH - count before this cycle's pop (no pop credit).
//   Accept lowest ports up to free; rest dropped, drop_cnt += dropped, saturates at 16'hFFFF.
//   enable=0: no pushes, drop_cnt unchanged.
// - Output: rec_valid = !empty; pop on rec_valid & rec_ready; rec stable while rec_valid & !rec_ready.
//   Latency release->rec_valid 1 cycle (registered write). Records leave in port order within a cycle.
// - inflight = popcount(valid), registered, updated same edge as table.
// - Reset mid-operation: table, FIFO, counters and errors cleared asynchronously; partial records discarded.
// STRUCTURE
// - vpu_prof_pkg: lc_rec_t struct, flag bit constants (ENQ, DEQ), issq index localparams.
// - Sub-module vpu_prof_mwfifo #(WIDTH, DEPTH, NWR): NWR-write/1-read FIFO, compacting push,
//   returns accepted count.
// - Top: table regs, per-tag priority select, release gather/compact, counters, error flags.
// TESTING
// - Dispatch vat 3 @t=10, enq q2 @12, deq @15, release @20 -> one record id=1,t_dis=10,t_enq=12,t_deq=15,t_rel=20,qidx=2.
// - 4 releases same cycle, FIFO holds 14/16, rec_ready=0 -> 2 records (ports 0,1) accepted, drop_cnt=2.
// - Release vat 5 + dispatch vat 5 same cycle -> record carries old id; entry holds new id; inflight unchanged.
// - Enq on never-dispatched vat 7 -> no table change, err_orphan=1 until reset.
// - Dispatch vat 4 twice without release -> err_reuse=1, second id kept, inflight +1 only once.
// - Reset asserted with 3 records queued and 5 in flight -> rec_valid=0, inflight=0, next id after reset =1.

Source files
------------

// File: rtl/vpu_lifecycle_tracker_pkg.sv
// Shared types for the VPU lifecycle tracker: record and table-entry layouts, flag
// bit positions and issue-queue ordering.
package vpu_lifecycle_tracker_pkg;

   localparam int unsigned ID_W     = 32;
   localparam int unsigned TS_W     = 32;
   localparam int unsigned QIDX_W   = 3;
   localparam int unsigned FLAG_W   = 2;
   localparam int unsigned FLAG_ENQ = 0;
   localparam int unsigned FLAG_DEQ = 1;

   // Issue-queue tap order on the enq/deq buses
   typedef enum logic [QIDX_W-1:0] {
      ISSQ_VL     = 3'd0,
      ISSQ_VS     = 3'd1,
      ISSQ_VP     = 3'd2,
      ISSQ_VX_INT = 3'd3,
      ISSQ_VX_FP  = 3'd4
   } issq_e;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [TS_W-1:0]   t_dis;
      logic [TS_W-1:0]   t_enq;
      logic [TS_W-1:0]   t_deq;
      logic [TS_W-1:0]   t_rel;
      logic [QIDX_W-1:0] qidx;
      logic [FLAG_W-1:0] flags;
   } lc_rec_t;

   typedef struct packed {
      logic              valid;
      logic [ID_W-1:0]   id;
      logic [TS_W-1:0]   t_dis;
      logic [TS_W-1:0]   t_enq;
      logic [TS_W-1:0]   t_deq;
      logic [QIDX_W-1:0] qidx;
      logic [FLAG_W-1:0] flags;
   } lc_entry_t;

   localparam int unsigned LC_REC_W = $bits(lc_rec_t);

endpackage

// File: rtl/vpu_lifecycle_tracker_mwfifo.sv
// Multi-write / single-read FIFO. Valid write ports are packed in port order into the
// free space seen at the start of the cycle; ports beyond that space are refused.
module vpu_lifecycle_tracker_mwfifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned NWR   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NWR-1:0]         wr_valid_i,
   input  logic [NWR*WIDTH-1:0]   wr_data_i,
   output logic [$clog2(DEPTH):0] acc_cnt_o,
   output logic                   rd_valid_o,
   output logic [WIDTH-1:0]       rd_data_o,
   input  logic                   rd_ready_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] free_c, n_acc_c;
   logic [NWR-1:0]   acc_c;
   logic [PTR_W-1:0] wr_idx_c [NWR];
   logic             pop_c;

   // Free space excludes this cycle's pop so a full FIFO never accepts on a read cycle
   always_comb begin
      free_c  = CNT_W'(DEPTH) - cnt_q;
      n_acc_c = '0;
      acc_c   = '0;
      for (int i = 0; i < NWR; i++) begin
         wr_idx_c[i] = wr_ptr_q + PTR_W'(n_acc_c);
         if (wr_valid_i[i] && (n_acc_c < free_c)) begin
            acc_c[i] = 1'b1;
            n_acc_c  = n_acc_c + CNT_W'(1);
         end
      end
   end

   assign pop_c      = rd_valid_o & rd_ready_i;
   assign rd_valid_o = (cnt_q != '0);
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign acc_cnt_o  = n_acc_c;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(n_acc_c);
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop_c);
         cnt_q    <= cnt_q + n_acc_c - CNT_W'(pop_c);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NWR; i++) begin
         if (acc_c[i]) mem_q[wr_idx_c[i]] <= wr_data_i[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/vpu_lifecycle_tracker.sv
// Per-VAT-tag lifecycle table fed by dispatch/issue/release taps; each release emits
// one lifecycle record into a trace FIFO drained over a valid/ready port.
module vpu_lifecycle_tracker
   import vpu_lifecycle_tracker_pkg::*;
#(
   parameter  int unsigned NUM_VAT    = 32,
   parameter  int unsigned NUM_ISSQ   = 5,
   parameter  int unsigned NUM_REL    = 4,
   parameter  int unsigned FIFO_DEPTH = 16,
   localparam int unsigned VAT_W      = $clog2(NUM_VAT)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic                      dis_fire_i,
   input  logic [VAT_W-1:0]          dis_vat_i,
   input  logic [NUM_ISSQ-1:0]       enq_fire_i,
   input  logic [NUM_ISSQ*VAT_W-1:0] enq_vat_i,
   input  logic [NUM_ISSQ-1:0]       deq_fire_i,
   input  logic [NUM_ISSQ*VAT_W-1:0] deq_vat_i,
   input  logic [NUM_REL-1:0]        rel_valid_i,
   input  logic [NUM_REL*VAT_W-1:0]  rel_vat_i,
   output logic                      rec_valid_o,
   input  logic                      rec_ready_i,
   output lc_rec_t                   rec_o,
   output logic [VAT_W:0]            inflight_o,
   output logic [15:0]               drop_cnt_o,
   output logic                      err_reuse_o,
   output logic                      err_orphan_o
);

   localparam int unsigned INF_W  = VAT_W + 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DROP_W = 16;

   lc_entry_t              tbl_q [NUM_VAT];
   lc_entry_t              tbl_d [NUM_VAT];
   logic [TS_W-1:0]        now_q;
   logic [ID_W-1:0]        next_id_q, next_id_d;
   logic [INF_W-1:0]       inflight_q, inflight_d;
   logic [DROP_W-1:0]      drop_q, drop_d;
   logic                   err_reuse_q, err_reuse_d;
   logic                   err_orphan_q, err_orphan_d;
   logic [NUM_VAT-1:0]     rel_hit_c;
   logic                   rel_orphan_c;
   logic [NUM_REL-1:0]     push_v_c;
   logic [NUM_REL*LC_REC_W-1:0] push_data_c;
   logic [CNT_W-1:0]       push_cnt_c, acc_cnt_c, dropped_c;
   logic [DROP_W:0]        drop_sum_c;
   logic [LC_REC_W-1:0]    rec_data_c;

   // Release gather: reads the pre-cycle table, first port per tag wins
   always_comb begin
      logic [VAT_W-1:0] tag;
      lc_rec_t          rec;
      tag          = '0;
      rec          = '0;
      rel_hit_c    = '0;
      rel_orphan_c = 1'b0;
      push_v_c     = '0;
      push_data_c  = '0;
      push_cnt_c   = '0;
      for (int r = 0; r < NUM_REL; r++) begin
         tag       = rel_vat_i[r*VAT_W +: VAT_W];
         rec.id    = tbl_q[tag].id;
         rec.t_dis = tbl_q[tag].t_dis;
         rec.t_enq = tbl_q[tag].t_enq;
         rec.t_deq = tbl_q[tag].t_deq;
         rec.t_rel = now_q;
         rec.qidx  = tbl_q[tag].qidx;
         rec.flags = tbl_q[tag].flags;
         if (rel_valid_i[r]) begin
            if (!tbl_q[tag].valid) begin
               rel_orphan_c = 1'b1;
            end else if (!rel_hit_c[tag]) begin
               rel_hit_c[tag] = 1'b1;
               push_v_c[r]    = enable_i;
               push_cnt_c     = push_cnt_c + CNT_W'(enable_i);
               push_data_c[r*LC_REC_W +: LC_REC_W] = rec;
            end
         end
      end
   end

   // Table next state: stamps, then invalidation, then dispatch overwrite
   always_comb begin
      logic [VAT_W-1:0] tag;
      tag          = '0;
      tbl_d        = tbl_q;
      next_id_d    = next_id_q;
      err_reuse_d  = err_reuse_q;
      err_orphan_d = err_orphan_q | rel_orphan_c;
      inflight_d   = '0;
      for (int q = int'(NUM_ISSQ) - 1; q >= 0; q--) begin
         if (enq_fire_i[q]) begin
            tag = enq_vat_i[q*VAT_W +: VAT_W];
            if (tbl_q[tag].valid) begin
               tbl_d[tag].t_enq           = now_q;
               tbl_d[tag].qidx            = QIDX_W'(q);
               tbl_d[tag].flags[FLAG_ENQ] = 1'b1;
            end else begin
               err_orphan_d = 1'b1;
            end
         end
      end
      for (int q = 0; q < NUM_ISSQ; q++) begin
         if (deq_fire_i[q]) begin
            tag = deq_vat_i[q*VAT_W +: VAT_W];
            if (tbl_q[tag].valid) begin
               tbl_d[tag].t_deq           = now_q;
               tbl_d[tag].flags[FLAG_DEQ] = 1'b1;
            end else begin
               err_orphan_d = 1'b1;
            end
         end
      end
      for (int v = 0; v < NUM_VAT; v++) begin
         if (rel_hit_c[v]) tbl_d[v].valid = 1'b0;
      end
      if (dis_fire_i) begin
         if (tbl_q[dis_vat_i].valid && !rel_hit_c[dis_vat_i]) err_reuse_d = 1'b1;
         tbl_d[dis_vat_i]       = '0;
         tbl_d[dis_vat_i].valid = 1'b1;
         tbl_d[dis_vat_i].id    = next_id_q;
         tbl_d[dis_vat_i].t_dis = now_q;
         next_id_d              = next_id_q + ID_W'(1);
      end
      for (int v = 0; v < NUM_VAT; v++) begin
         inflight_d = inflight_d + INF_W'(tbl_d[v].valid);
      end
   end

   assign dropped_c  = push_cnt_c - acc_cnt_c;
   assign drop_sum_c = (DROP_W+1)'(drop_q) + (DROP_W+1)'(dropped_c);
   assign drop_d     = drop_sum_c[DROP_W] ? '1 : drop_sum_c[DROP_W-1:0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int v = 0; v < NUM_VAT; v++) tbl_q[v] <= '0;
         now_q        <= '0;
         next_id_q    <= ID_W'(1);
         inflight_q   <= '0;
         drop_q       <= '0;
         err_reuse_q  <= 1'b0;
         err_orphan_q <= 1'b0;
      end else begin
         tbl_q        <= tbl_d;
         now_q        <= now_q + TS_W'(1);
         next_id_q    <= next_id_d;
         inflight_q   <= inflight_d;
         drop_q       <= drop_d;
         err_reuse_q  <= err_reuse_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   vpu_lifecycle_tracker_mwfifo #(
      .WIDTH (LC_REC_W),
      .DEPTH (FIFO_DEPTH),
      .NWR   (NUM_REL)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_valid_i (push_v_c),
      .wr_data_i  (push_data_c),
      .acc_cnt_o  (acc_cnt_c),
      .rd_valid_o (rec_valid_o),
      .rd_data_o  (rec_data_c),
      .rd_ready_i (rec_ready_i)
   );

   assign rec_o        = rec_data_c;
   assign inflight_o   = inflight_q;
   assign drop_cnt_o   = drop_q;
   assign err_reuse_o  = err_reuse_q;
   assign err_orphan_o = err_orphan_q;

endmodule

// File: tb/tb_vpu_lifecycle_tracker.sv
// Bench for vpu_lifecycle_tracker: directed lifecycle scenarios plus randomized traffic
// checked every cycle against a transaction-level model of table, record queue and counters.
module tb_vpu_lifecycle_tracker;
   import vpu_lifecycle_tracker_pkg::*;

   localparam int NV = 32;
   localparam int NQ = 5;
   localparam int NR = 4;
   localparam int DEPTH = 16;
   localparam int VW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable, dis_fire, rec_ready;
   logic [VW-1:0] dis_vat;
   logic [NQ-1:0] enq_fire, deq_fire;
   logic [NQ*VW-1:0] enq_vat, deq_vat;
   logic [NR-1:0] rel_valid;
   logic [NR*VW-1:0] rel_vat;
   logic          rec_valid, err_reuse, err_orphan;
   lc_rec_t       rec;
   logic [VW:0]   inflight;
   logic [15:0]   drop_cnt;

   vpu_lifecycle_tracker dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable),
      .dis_fire_i(dis_fire), .dis_vat_i(dis_vat),
      .enq_fire_i(enq_fire), .enq_vat_i(enq_vat),
      .deq_fire_i(deq_fire), .deq_vat_i(deq_vat),
      .rel_valid_i(rel_valid), .rel_vat_i(rel_vat),
      .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_o(rec),
      .inflight_o(inflight), .drop_cnt_o(drop_cnt),
      .err_reuse_o(err_reuse), .err_orphan_o(err_orphan)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit          m_valid [NV];
   logic [31:0] m_id [NV], m_tdis [NV], m_tenq [NV], m_tdeq [NV];
   int          m_qidx [NV];
   logic [1:0]  m_flags [NV];
   logic [31:0] m_now, m_next_id;
   int          m_drop;
   bit          m_reuse, m_orphan;
   lc_rec_t     mq [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         m_valid[v] = 0; m_id[v] = 0; m_tdis[v] = 0; m_tenq[v] = 0;
         m_tdeq[v] = 0; m_qidx[v] = 0; m_flags[v] = 0;
      end
      m_now = 0; m_next_id = 1; m_drop = 0; m_reuse = 0; m_orphan = 0;
      mq.delete();
   endtask

   // One clock edge worth of behaviour, applied from the inputs currently driven
   task automatic model_step();
      bit pv [NV];
      bit rel_done [NV];
      bit enq_done [NV];
      lc_rec_t cand [$];
      lc_rec_t r;
      int t, free;
      pv = m_valid;
      for (int v = 0; v < NV; v++) begin rel_done[v] = 0; enq_done[v] = 0; end
      for (int p = 0; p < NR; p++) begin
         if (rel_valid[p]) begin
            t = int'(rel_vat[p*VW +: VW]);
            if (!pv[t]) m_orphan = 1;
            else if (!rel_done[t]) begin
               rel_done[t] = 1;
               if (enable) begin
                  r.id = m_id[t]; r.t_dis = m_tdis[t]; r.t_enq = m_tenq[t];
                  r.t_deq = m_tdeq[t]; r.t_rel = m_now;
                  r.qidx = 3'(m_qidx[t]); r.flags = m_flags[t];
                  cand.push_back(r);
               end
            end
         end
      end
      free = DEPTH - mq.size();
      if (mq.size() > 0 && rec_ready) void'(mq.pop_front());
      foreach (cand[i]) begin
         if (i < free) mq.push_back(cand[i]);
         else m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
      end
      for (int q = 0; q < NQ; q++) begin
         if (enq_fire[q]) begin
            t = int'(enq_vat[q*VW +: VW]);
            if (!pv[t]) m_orphan = 1;
            else if (!enq_done[t]) begin
               enq_done[t] = 1;
               m_tenq[t] = m_now; m_qidx[t] = q; m_flags[t][0] = 1'b1;
            end
         end
      end
      for (int q = 0; q < NQ; q++) begin
         if (deq_fire[q]) begin
            t = int'(deq_vat[q*VW +: VW]);
            if (!pv[t]) m_orphan = 1;
            else begin m_tdeq[t] = m_now; m_flags[t][1] = 1'b1; end
         end
      end
      for (int v = 0; v < NV; v++) if (rel_done[v]) m_valid[v] = 0;
      if (dis_fire) begin
         t = int'(dis_vat);
         if (pv[t] && !rel_done[t]) m_reuse = 1;
         m_valid[t] = 1; m_id[t] = m_next_id; m_tdis[t] = m_now;
         m_tenq[t] = 0; m_tdeq[t] = 0; m_qidx[t] = 0; m_flags[t] = 0;
         m_next_id = m_next_id + 1;
      end
      m_now = m_now + 1;
   endtask

   task automatic check_outputs();
      int cnt = 0;
      foreach (m_valid[v]) cnt += int'(m_valid[v]);
      chk("rec_valid", 256'(rec_valid), 256'(mq.size() != 0));
      if (mq.size() != 0) chk("rec", 256'(rec), 256'(mq[0]));
      chk("inflight", 256'(inflight), 256'(cnt));
      chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
      chk("err_reuse", 256'(err_reuse), 256'(m_reuse));
      chk("err_orphan", 256'(err_orphan), 256'(m_orphan));
   endtask

   task automatic idle();
      dis_fire = 0; dis_vat = '0; enq_fire = '0; enq_vat = '0;
      deq_fire = '0; deq_vat = '0; rel_valid = '0; rel_vat = '0;
   endtask

   // Inputs are set at a negedge; model and DUT both consume them at the next posedge
   task automatic cycle();
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run_until(input logic [31:0] t);
      for (int k = 0; k < 1000 && m_now != t; k++) begin idle(); cycle(); end
   endtask

   task automatic do_reset();
      rst = 1'b1; idle(); rec_ready = 1'b0; enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      check_outputs();
   endtask

   task automatic rand_inputs(input int tag_max, input int ready_pct);
      enable   = ($urandom_range(0, 9) != 0);
      dis_fire = ($urandom_range(0, 2) == 0);
      dis_vat  = VW'($urandom_range(0, tag_max));
      for (int q = 0; q < NQ; q++) begin
         enq_fire[q] = ($urandom_range(0, 4) == 0);
         enq_vat[q*VW +: VW] = VW'($urandom_range(0, tag_max));
         deq_fire[q] = ($urandom_range(0, 4) == 0);
         deq_vat[q*VW +: VW] = VW'($urandom_range(0, tag_max));
      end
      for (int p = 0; p < NR; p++) begin
         rel_valid[p] = ($urandom_range(0, 3) == 0);
         rel_vat[p*VW +: VW] = VW'($urandom_range(0, tag_max));
      end
      rec_ready = ($urandom_range(0, 99) < ready_pct);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; rec_ready = 1'b0; idle();
      #1;
      model_reset();
      chk("reset_rec_valid", 256'(rec_valid), 256'(0));
      chk("reset_inflight", 256'(inflight), 256'(0));

      // Single lifecycle with known timestamps
      do_reset();
      run_until(10);
      dis_fire = 1; dis_vat = 5'd3; cycle();
      run_until(12);
      enq_fire = 5'b00100; enq_vat[2*VW +: VW] = 5'd3; cycle();
      run_until(15);
      deq_fire = 5'b00100; deq_vat[2*VW +: VW] = 5'd3; cycle();
      run_until(20);
      rel_valid = 4'b0001; rel_vat[0 +: VW] = 5'd3; cycle();
      chk("s1_valid", 256'(rec_valid), 256'(1));
      chk("s1_id", 256'(rec.id), 256'(1));
      chk("s1_tdis", 256'(rec.t_dis), 256'(10));
      chk("s1_tenq", 256'(rec.t_enq), 256'(12));
      chk("s1_tdeq", 256'(rec.t_deq), 256'(15));
      chk("s1_trel", 256'(rec.t_rel), 256'(20));
      chk("s1_qidx", 256'(rec.qidx), 256'(2));
      chk("s1_flags", 256'(rec.flags), 256'(3));
      rec_ready = 1; idle(); cycle();
      chk("s1_drained", 256'(rec_valid), 256'(0));

      // FIFO at 14/16 hit by four simultaneous releases
      do_reset();
      for (int i = 0; i < 18; i++) begin idle(); dis_fire = 1; dis_vat = VW'(i); cycle(); end
      for (int i = 0; i < 14; i++) begin idle(); rel_valid = 4'b0001; rel_vat[0 +: VW] = VW'(i); cycle(); end
      idle(); rel_valid = 4'b1111;
      for (int p = 0; p < NR; p++) rel_vat[p*VW +: VW] = VW'(14 + p);
      cycle();
      chk("s2_drop", 256'(drop_cnt), 256'(2));
      idle(); rec_ready = 1;
      for (int i = 0; i < 18; i++) cycle();
      chk("s2_empty", 256'(rec_valid), 256'(0));

      // Release and re-dispatch of the same tag in one cycle
      do_reset();
      dis_fire = 1; dis_vat = 5'd5; cycle();
      idle(); dis_fire = 1; dis_vat = 5'd5; rel_valid = 4'b0001; rel_vat[0 +: VW] = 5'd5; cycle();
      chk("s3_old_id", 256'(rec.id), 256'(1));
      chk("s3_inflight", 256'(inflight), 256'(1));
      chk("s3_no_reuse", 256'(err_reuse), 256'(0));
      rec_ready = 1; idle(); rel_valid = 4'b0001; rel_vat[0 +: VW] = 5'd5; cycle();
      chk("s3_new_id", 256'(rec.id), 256'(2));

      // Orphan enq on a never-dispatched tag
      do_reset();
      enq_fire = 5'b00001; enq_vat[0 +: VW] = 5'd7; cycle();
      idle(); for (int i = 0; i < 3; i++) cycle();
      chk("s4_orphan", 256'(err_orphan), 256'(1));
      chk("s4_inflight", 256'(inflight), 256'(0));

      // Double dispatch of the same tag
      do_reset();
      dis_fire = 1; dis_vat = 5'd4; cycle();
      dis_fire = 1; dis_vat = 5'd4; cycle();
      chk("s5_reuse", 256'(err_reuse), 256'(1));
      chk("s5_inflight", 256'(inflight), 256'(1));
      idle(); rec_ready = 1; rel_valid = 4'b0001; rel_vat[0 +: VW] = 5'd4; cycle();
      chk("s5_id", 256'(rec.id), 256'(2));

      // Reset with records queued and tags in flight
      do_reset();
      for (int i = 0; i < 8; i++) begin idle(); dis_fire = 1; dis_vat = VW'(i); cycle(); end
      for (int i = 0; i < 3; i++) begin idle(); rel_valid = 4'b0001; rel_vat[0 +: VW] = VW'(i); cycle(); end
      idle();
      rst = 1'b1;
      #1;
      chk("s6_rst_valid", 256'(rec_valid), 256'(0));
      chk("s6_rst_inflight", 256'(inflight), 256'(0));
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      dis_fire = 1; dis_vat = 5'd9; cycle();
      idle(); rel_valid = 4'b0001; rel_vat[0 +: VW] = 5'd9; cycle();
      chk("s6_first_id", 256'(rec.id), 256'(1));

      // Randomized traffic: dense tags, sparse tags, back-pressure and mixed phases
      for (int ph = 0; ph < 4; ph++) begin
         do_reset();
         for (int c = 0; c < 800; c++) begin
            rand_inputs((ph % 2 == 0) ? 7 : 31, (ph == 2) ? 10 : 60);
            cycle();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
